// File: rtl/multicycle_alu_control.sv
// Issue control for single-cycle ALU ops and iterative MULTU/DIVU with HiLo writeback.
// Define MCALU_ILLEGAL_EN to flag unrecognised funct codes instead of passing them through.
module multicycle_alu_control #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [5:0]       funct,
    output logic [5:0]       op_out,
    output logic             hilo_we,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter,
    output logic             illegal
);

    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_HILO = 6'h3f;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        WB
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [5:0]       r_op;
    logic [5:0]       w_op_nx;
    logic [CNT_W-1:0] r_iter;
    logic [CNT_W-1:0] w_iter_nx;
    logic             r_busy;
    logic             w_busy_nx;
    logic             r_we;
    logic             w_we_nx;
    logic             r_done;
    logic             w_done_nx;
    logic             r_ill;
    logic             w_ill_nx;
    logic             w_multi;

    assign w_multi = (funct == F_MULTU) || (funct == F_DIVU);

`ifdef MCALU_ILLEGAL_EN
    logic w_known;
    assign w_known = funct inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42,
                                   6'd2, 6'd16, 6'd18};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= OP_NOP;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_op    <= w_op_nx;
            r_iter  <= w_iter_nx;
            r_busy  <= w_busy_nx;
            r_we    <= w_we_nx;
            r_done  <= w_done_nx;
            r_ill   <= w_ill_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_op_nx    = OP_NOP;
        w_iter_nx  = r_iter;
        w_busy_nx  = 1'b0;
        w_we_nx    = 1'b0;
        w_done_nx  = 1'b0;
        w_ill_nx   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_iter_nx = '0;
                if (valid && w_multi) begin
                    w_state_nx = (funct == F_DIVU) ? DIV : MUL;
                    w_op_nx    = funct;
                    w_busy_nx  = 1'b1;
                end else if (valid) begin
`ifdef MCALU_ILLEGAL_EN
                    if (w_known) w_op_nx = funct;
                    else         w_ill_nx = 1'b1;
`else
                    w_op_nx = funct;
`endif
                end
            end
            MUL, DIV: begin
                // issue requests are ignored while iterating; op code stays latched
                w_busy_nx = 1'b1;
                if (r_iter == LAST) begin
                    w_state_nx = WB;
                    w_op_nx    = OP_HILO;
                    w_we_nx    = 1'b1;
                    w_done_nx  = 1'b1;
                end else begin
                    w_iter_nx = r_iter + ONE;
                    w_op_nx   = r_op;
                end
            end
            WB: begin
                w_state_nx = IDLE;
                w_iter_nx  = '0;
            end
            default: begin
                w_state_nx = IDLE;
                w_iter_nx  = '0;
            end
        endcase
    end

    assign op_out  = r_op;
    assign hilo_we = r_we;
    assign busy    = r_busy;
    assign done    = r_done;
    assign iter    = r_iter;
    assign illegal = r_ill;

endmodule

// File: tb/tb_multicycle_alu_control.sv
// Testbench for multicycle_alu_control: vector table, corner sequences, random vs model.
// Expectations for unknown funct codes follow MCALU_ILLEGAL_EN.
module tb_multicycle_alu_control;

    localparam int DW = 32;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [5:0]    funct = '0;
    logic [5:0]    op_out;
    logic          hilo_we;
    logic          busy;
    logic          done;
    logic [CW-1:0] iter;
    logic          illegal;

    multicycle_alu_control #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .funct(funct),
        .op_out(op_out), .hilo_we(hilo_we), .busy(busy), .done(done),
        .iter(iter), .illegal(illegal)
    );

    always #5 clk = ~clk;

`ifdef MCALU_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit known(input logic [5:0] f);
        return f inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2,
                         6'd16, 6'd18, 6'd25, 6'd27};
    endfunction

    // Reference model: time elapsed since a multi-cycle issue, -1 when free.
    int         m_t = -1;
    logic [5:0] m_lat;
    logic [5:0] e_op;
    logic       e_we, e_busy, e_done, e_ill, e_iter_chk;
    int         e_iter;

    task automatic model(input logic v, input logic [5:0] f);
        e_we = 0; e_done = 0; e_ill = 0; e_iter = 0; e_iter_chk = 1;
        e_busy = 0; e_op = 0;
        if (m_t < 0) begin
            if (v && (f == 6'd25 || f == 6'd27)) begin
                m_t = 0; m_lat = f; e_busy = 1; e_op = f;
            end else if (v) begin
                if (ILL_EN && !known(f)) e_ill = 1;
                else e_op = f;
            end
        end else begin
            m_t++;
            if (m_t < DW) begin
                e_busy = 1; e_op = m_lat; e_iter = m_t;
            end else if (m_t == DW) begin
                e_busy = 1; e_op = 6'h3f; e_we = 1; e_done = 1; e_iter_chk = 0;
            end else begin
                m_t = -1;
            end
        end
    endtask

    task automatic edge_drive(input logic v, input logic [5:0] f);
        @(negedge clk);
        valid = v;
        funct = f;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [5:0] f);
        edge_drive(v, f);
        model(v, f);
        chk("op_out", op_out, e_op);
        chk("hilo_we", hilo_we, e_we);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("illegal", illegal, e_ill);
        if (e_iter_chk) chk("iter", iter, e_iter);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".op"}, op_out, 0);
        chk({nm, ".we"}, hilo_we, 0);
        chk({nm, ".busy"}, busy, 0);
        chk({nm, ".done"}, done, 0);
        chk({nm, ".iter"}, iter, 0);
        chk({nm, ".ill"}, illegal, 0);
    endtask

    typedef struct {
        logic       v;
        logic [5:0] f;
        logic [5:0] op;
        logic       ill;
    } vec_t;

    vec_t vt[$];

    initial begin
        int nb, nwe, k, idle_gap, first_busy_end;
        logic [5:0] pool [12];

        vt.push_back('{1'b1, 6'd32, 6'd32, 1'b0});
        vt.push_back('{1'b0, 6'd32, 6'd0, 1'b0});
        vt.push_back('{1'b1, 6'd36, 6'd36, 1'b0});
        vt.push_back('{1'b1, 6'd37, 6'd37, 1'b0});
        vt.push_back('{1'b1, 6'd34, 6'd34, 1'b0});
        vt.push_back('{1'b1, 6'd42, 6'd42, 1'b0});
        vt.push_back('{1'b1, 6'd2, 6'd2, 1'b0});
        vt.push_back('{1'b1, 6'd16, 6'd16, 1'b0});
        vt.push_back('{1'b1, 6'd18, 6'd18, 1'b0});
        vt.push_back('{1'b0, 6'd63, 6'd0, 1'b0});
        vt.push_back('{1'b1, 6'd63, ILL_EN ? 6'd0 : 6'd63, ILL_EN});
        vt.push_back('{1'b1, 6'd0, 6'd0, ILL_EN});
        vt.push_back('{1'b1, 6'd33, ILL_EN ? 6'd0 : 6'd33, ILL_EN});
        vt.push_back('{1'b0, 6'd0, 6'd0, 1'b0});

        #12;
        check_zero("reset");
        #4 rst_n = 1'b1;

        // first edge after reset release accepts ADD, then NOP
        step(1'b1, 6'd32);
        step(1'b0, 6'd0);

        foreach (vt[i]) begin
            edge_drive(vt[i].v, vt[i].f);
            chk($sformatf("vec%0d.op", i), op_out, vt[i].op);
            chk($sformatf("vec%0d.ill", i), illegal, vt[i].ill);
            chk($sformatf("vec%0d.busy", i), busy, 0);
            chk($sformatf("vec%0d.we", i), hilo_we, 0);
        end

        // MULTU: busy DW+1 cycles, one hilo_we in the cycle after the DW-th edge
        step(1'b1, 6'd25);
        nb = busy ? 1 : 0;
        nwe = 0;
        for (int s = 1; s <= DW + 2; s++) begin
            step(1'b0, 6'd0);
            if (busy) nb++;
            if (hilo_we) begin
                nwe++;
                chk("multu.we_cycle", s, DW);
            end
        end
        chk("multu.busy_cycles", nb, DW + 1);
        chk("multu.we_count", nwe, 1);

        // DIVU then ADD held: ADD accepted on the first IDLE edge
        step(1'b1, 6'd27);
        k = 0;
        while (op_out != 6'd32 && k < 3 * DW) begin
            step(1'b1, 6'd32);
            k++;
        end
        chk("divu_hold.accept_edge", k, DW + 2);
        chk("divu_hold.op", op_out, 6'd32);
        step(1'b0, 6'd0);

        // back-to-back MULTU then DIVU with a single idle cycle between
        step(1'b1, 6'd25);
        idle_gap = 0;
        first_busy_end = 0;
        for (int s = 1; s <= DW + 3; s++) begin
            step(1'b1, 6'd27);
            if (!busy) idle_gap++;
            if (!busy && first_busy_end == 0) first_busy_end = s;
        end
        chk("b2b.first_end", first_busy_end, DW + 1);
        chk("b2b.idle_gap", idle_gap, 1);
        chk("b2b.divu_op", op_out, 6'd27);
        for (int s = 0; s < DW + 2; s++) step(1'b0, 6'd0);

        // reset in the middle of MULTU
        step(1'b1, 6'd25);
        for (int s = 0; s < 10; s++) step(1'b0, 6'd0);
        chk("midrst.iter10", iter, 10);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        #1 rst_n = 1'b1;
        m_t = -1;
        nwe = 0;
        for (int s = 0; s < DW + 4; s++) begin
            step(1'b0, 6'd0);
            if (hilo_we) nwe++;
        end
        chk("midrst.no_we", nwe, 0);
        step(1'b1, 6'd25);
        chk("midrst.restart_iter", iter, 0);
        chk("midrst.restart_busy", busy, 1);
        for (int s = 0; s < DW + 2; s++) step(1'b0, 6'd0);

        // random traffic against the model
        pool = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd27,
                 6'd16, 6'd18, 6'd63, 6'd0};
        for (int s = 0; s < 1500; s++) begin
            logic [5:0] f;
            if ($urandom_range(3) == 0) f = 6'($urandom_range(63));
            else f = pool[$urandom_range(11)];
            step(1'($urandom_range(1)), f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_alu_control.md
MULTICYCLE_ALU_CONTROL -- requirements
Module: multicycle_alu_control

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: operand width; sets multi-cycle iteration count (legal 8..64).
REQ-002 SHALL provide parameter CNT_W, default 7: iteration counter width; must satisfy 2**CNT_W > DATA_W.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port valid  input  1  instruction issue strobe; funct sampled when high.
REQ-006 SHALL have port funct  input  6  R-type funct code.
REQ-007 SHALL have port op_out  output  6  registered op code, shared by ALU/shifter/multiplier/divider/mux.
REQ-008 SHALL have port hilo_we  output  1  one-cycle HiLo write enable.
REQ-009 SHALL have port busy  output  1  multi-cycle op in progress; new issues are refused.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port iter  output  CNT_W  current iteration index.
REQ-012 SHALL have port illegal  output  1  one-cycle unknown-funct flag.

Function
REQ-013 Recognised funct codes SHALL be: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, DIVU 27, MFHI 16, MFLO 18.
REQ-014 FSM SHALL have states IDLE, MUL, DIV, WB; all outputs registered.
REQ-015 IDLE, valid=1, single-cycle code: op_out SHALL equal funct after that edge, for one cycle; state stays IDLE.
REQ-016 IDLE, valid=0: op_out SHALL be 000000 (NOP) after the edge.
REQ-017 IDLE, valid=1, MULTU/DIVU: next state MUL/DIV, iter=0, busy=1, op_out holds the latched funct.
REQ-018 In MUL/DIV, iter SHALL increment by 1 per edge; at the edge where iter==DATA_W-1, state goes to WB.
REQ-019 In WB: op_out=111111 (HiLo open), hilo_we=1, done=1, busy=1, for exactly one cycle; next edge returns to IDLE with iter=0.
REQ-020 busy SHALL be high for exactly DATA_W+1 cycles per MULTU/DIVU (DATA_W in MUL/DIV plus WB).
REQ-021 valid while busy=1 SHALL be ignored: no state, op_out or flag change; the issuer must hold and retry.
REQ-022 valid in WB cycle SHALL be ignored; a new issue is accepted on the first IDLE cycle.
REQ-023 hilo_we and done SHALL be low in every state other than WB.
REQ-024 Back-to-back MULTU then DIVU SHALL each take DATA_W+1 busy cycles with one IDLE cycle between.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, op_out=000000, iter=0, hilo_we=0, busy=0, done=0, illegal=0.
REQ-026 Reset mid MUL/DIV/WB SHALL abort the operation with no hilo_we pulse; the op is lost.
REQ-027 First issue SHALL be accepted on the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 Macro MCALU_ILLEGAL_EN SHALL compile in funct checking.
REQ-029 With MCALU_ILLEGAL_EN: IDLE, valid=1, unrecognised funct -> op_out=000000 and illegal=1 for one cycle, state IDLE.
REQ-030 Without MCALU_ILLEGAL_EN: unrecognised funct passes to op_out unchanged; illegal SHALL be tied 0.

Verification
REQ-031 DATA_W=32, issue ADD (32) -> op_out=100000 one cycle after, then 000000; busy stays 0.
REQ-032 DATA_W=32, issue MULTU (25) at edge E0 -> busy 1 from E0 to E33; iter 0..31; op_out=111111, hilo_we=1, done=1 only in cycle after E32.
REQ-033 DATA_W=8, issue DIVU (27) then hold valid with ADD -> ADD ignored for 9 busy cycles, accepted on first IDLE edge; op_out=100000.
REQ-034 MULTU issued, rst_n pulsed low at iter=10 -> all outputs 0 immediately; no hilo_we ever seen; next MULTU restarts at iter=0.
REQ-035 MCALU_ILLEGAL_EN defined, issue funct 63 -> illegal=1 for one cycle, op_out=000000; undefined -> op_out=111111, illegal=0.
